ex_branch_resolver: RTL and testbench
=====================================

// Module: ex_branch_resolver
// PURPOSE
//   Consumer end of the EX-stage ALU: takes the ALU result/Zero flag plus decoded control-flow info,
//   resolves branches/jumps, and drives the registered PC redirect plus pipeline flush. Sits between
//   EX and the IF/ID/EX pipeline registers. Branch ALUOps produce Zero=1 exactly when the branch is
//   taken (beq via sub, bne/blt/bge/bltu/bgeu via inverted compare); this block relies on that.
// PARAMETERS
//   FLUSH_CYCLES  2   cycles flush_front held after a redirect (IF/ID + ID/EX bubbles), range 1..7
//   RESET_PC      0   value of redirect_pc after reset
// PORTS
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous, active-high reset
//   ex_valid       in   1   EX stage holds a real instruction
//   ex_is_branch   in   1   conditional branch (B-type)
//   ex_is_jal      in   1   jal
//   ex_is_jalr     in   1   jalr; alu_c carries rs1+imm
//   ex_pc          in   32  PC of EX instruction
//   ex_imm         in   32  sign-extended immediate
//   alu_c          in   32  ALU result C
//   alu_zero       in   1   ALU Zero flag
//   stall          in   1   downstream stall; EX contents frozen
//   redirect_valid out  1   one-cycle pulse: fetch must load redirect_pc
//   redirect_pc    out  32  target address
//   flush_front    out  1   squash IF/ID and ID/EX registers
//   link_valid     out  1   registered: link value valid for writeback (jal/jalr)
//   link_data      out  32  ex_pc+4 of the jump
//   misalign_exc   out  1   one-cycle pulse: taken target with target[1:0]!=0
//   perf_branches  out  32  resolved conditional branches (see CONFIGURATION)
//   perf_taken     out  32  taken conditional branches (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=IDLE, redirect_valid=0, redirect_pc=RESET_PC, flush_front=0, link_valid=0,
//     link_data=0, misalign_exc=0, perf counters=0. Reset asserted mid-FLUSH aborts to IDLE.
//   Resolve condition: fire = ex_valid & ~stall & state==IDLE.
//   taken = fire & (ex_is_jal | ex_is_jalr | (ex_is_branch & alu_zero)).
//   Target: branch/jal = ex_pc+ex_imm (32-bit, wraps mod 2^32); jalr = alu_c & ~32'h1.
//   Latency 1: outputs registered on the edge after fire.
//   States: IDLE -> (taken & target[1:0]==0) -> FLUSH: redirect_valid=1 for first cycle only,
//     flush_front=1 for FLUSH_CYCLES cycles (down-counter), then back to IDLE.
//     IDLE -> (taken & target[1:0]!=0): misalign_exc pulses 1 cycle, no redirect, no flush, stay IDLE.
//   While in FLUSH, ex_valid is ignored (instruction is a squashed wrong-path op): no redirect,
//     no link, no count. stall does not extend FLUSH; counter decrements every cycle.
//   link_valid/link_data: on fire with jal|jalr, next cycle link_valid=1, link_data=ex_pc+4;
//     asserted even on misaligned target. Otherwise link_valid=0 next cycle.
//   Multiple ex_is_* high together: priority jalr > jal > branch.
//   Not-taken branch: no outputs change except perf counters.
//   stall high: nothing resolves, all pulses deassert, registered values hold.
// CONFIGURATION
//   BRANCH_PERF_EN defined: perf_branches += 1 on fire & ex_is_branch & ~jal & ~jalr;
//     perf_taken += 1 when additionally alu_zero. Both wrap 32'hFFFFFFFF -> 0.
//   Undefined: counters not instantiated, perf_branches and perf_taken tied to 32'h0.
// TESTING
//   beq taken: ex_pc=0x100, ex_imm=0x20, alu_zero=1 -> next cycle redirect_pc=0x120, pulse 1 cycle,
//     flush_front high exactly 2 cycles.
//   bne not taken: alu_zero=0 -> redirect_valid/flush_front stay 0; perf_branches=1, perf_taken=0.
//   jalr: alu_c=0x2003, ex_pc=0x40 -> redirect_pc=0x2002 misaligned -> misalign_exc pulse, no flush,
//     link_valid=1 with link_data=0x44.
//   back-to-back: taken jal at ex_pc=0x80 (imm 0x100), then ex_valid jal at next cycle -> second
//     ignored; single redirect to 0x180.
//   stall: taken branch with stall=1 for 3 cycles -> no redirect until stall drops, then 1-cycle latency.
//   rst asserted in 2nd flush cycle -> flush_front=0 immediately, redirect_pc=RESET_PC, state IDLE.

Source files
------------

// File: rtl/ex_branch_resolver.sv
// ex_branch_resolver: EX-stage control-flow resolver.
// Takes the ALU result and Zero flag with the decoded branch/jump info. It
// resolves the instruction and produces a registered PC redirect and front-end
// flush, the link value for jal/jalr, and a misaligned-target exception pulse.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   ex_valid        EX holds a real instruction
//   ex_is_branch    conditional branch (taken when alu_zero=1)
//   ex_is_jal       jal  (target ex_pc+ex_imm)
//   ex_is_jalr      jalr (target alu_c with bit 0 cleared)
//   ex_pc, ex_imm   PC and sign-extended immediate of the EX instruction
//   alu_c, alu_zero ALU result and Zero flag
//   stall           downstream stall; EX contents frozen, nothing resolves
//   redirect_valid  one-cycle pulse: fetch loads redirect_pc
//   redirect_pc     redirect target (RESET_PC after reset)
//   flush_front     squash IF/ID and ID/EX for FLUSH_CYCLES cycles
//   link_valid      link_data is valid for writeback (jal/jalr)
//   link_data       ex_pc+4 of the resolved jump
//   misalign_exc    one-cycle pulse: taken target not word aligned
//   perf_branches   resolved conditional branch count
//   perf_taken      taken conditional branch count
//
// Build option: define BRANCH_PERF_EN to instantiate the perf counters;
// without it perf_branches and perf_taken are tied to zero.
module ex_branch_resolver #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_is_jal,
    input  logic        ex_is_jalr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_imm,
    input  logic [31:0] alu_c,
    input  logic        alu_zero,
    input  logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_front,
    output logic        link_valid,
    output logic [31:0] link_data,
    output logic        misalign_exc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_taken
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               redirect_valid_nx;
    logic [DATA_W-1:0]  redirect_pc_nx;
    logic               flush_front_nx;
    logic               link_valid_nx;
    logic [DATA_W-1:0]  link_data_nx;
    logic               misalign_exc_nx;

    logic               fire;
    logic               sel_jalr;
    logic               sel_jal;
    logic               sel_branch;
    logic               is_jump;
    logic               taken;
    logic [DATA_W-1:0]  target;
    logic               target_misaligned;

    // Decode with priority jalr > jal > branch; wrong-path ops in FLUSH never fire.
    always_comb begin
        fire              = ex_valid & ~stall & (state == IDLE);
        sel_jalr          = ex_is_jalr;
        sel_jal           = ex_is_jal & ~ex_is_jalr;
        sel_branch        = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
        is_jump           = sel_jal | sel_jalr;
        // The ALU is set up so that Zero=1 exactly when the branch is taken.
        taken             = fire & (is_jump | (sel_branch & alu_zero));
        target            = sel_jalr ? (alu_c & ~DATA_W'(1)) : (ex_pc + ex_imm);
        target_misaligned = (target[1:0] != 2'b00);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            flush_front    <= 1'b0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            misalign_exc   <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            redirect_valid <= redirect_valid_nx;
            redirect_pc    <= redirect_pc_nx;
            flush_front    <= flush_front_nx;
            link_valid     <= link_valid_nx;
            link_data      <= link_data_nx;
            misalign_exc   <= misalign_exc_nx;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        redirect_valid_nx = 1'b0;
        redirect_pc_nx    = redirect_pc;
        flush_front_nx    = flush_front;
        link_valid_nx     = 1'b0;
        link_data_nx      = link_data;
        misalign_exc_nx   = 1'b0;

        case (state)
            IDLE: begin
                flush_front_nx = 1'b0;
                // Link is written back even when the jump target faults.
                if (fire && is_jump) begin
                    link_valid_nx = 1'b1;
                    link_data_nx  = ex_pc + DATA_W'(4);
                end
                if (taken) begin
                    // Faulting target is kept in redirect_pc for the trap handler.
                    redirect_pc_nx = target;
                    if (target_misaligned) begin
                        misalign_exc_nx = 1'b1;
                    end else begin
                        state_nx          = FLUSH;
                        redirect_valid_nx = 1'b1;
                        flush_front_nx    = 1'b1;
                        cnt_nx            = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                // Counts down every cycle regardless of stall.
                if (cnt == '0) begin
                    state_nx       = IDLE;
                    flush_front_nx = 1'b0;
                end else begin
                    cnt_nx         = cnt - CNT_W'(1);
                    flush_front_nx = 1'b1;
                end
            end
            default: begin
                state_nx       = IDLE;
                flush_front_nx = 1'b0;
            end
        endcase
    end

`ifdef BRANCH_PERF_EN
    logic [DATA_W-1:0] perf_branches_q;
    logic [DATA_W-1:0] perf_taken_q;

    // Conditional-branch counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches_q <= '0;
            perf_taken_q    <= '0;
        end else if (fire && sel_branch) begin
            perf_branches_q <= perf_branches_q + DATA_W'(1);
            if (alu_zero) begin
                perf_taken_q <= perf_taken_q + DATA_W'(1);
            end
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_taken    = perf_taken_q;
`else
    assign perf_branches = '0;
    assign perf_taken    = '0;
`endif

endmodule

// File: tb/tb_ex_branch_resolver.sv
// Directed-vector bench for ex_branch_resolver (FLUSH_CYCLES=2, RESET_PC=0).
module tb_ex_branch_resolver;

`ifdef BRANCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [31:0] ex_pc, ex_imm, alu_c;
    logic        alu_zero, stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_front;
    logic        link_valid;
    logic [31:0] link_data;
    logic        misalign_exc;
    logic [31:0] perf_branches, perf_taken;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ex_branch_resolver #(
        .FLUSH_CYCLES(2),
        .RESET_PC    (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jal     (ex_is_jal),
        .ex_is_jalr    (ex_is_jalr),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .alu_c         (alu_c),
        .alu_zero      (alu_zero),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .flush_front   (flush_front),
        .link_valid    (link_valid),
        .link_data     (link_data),
        .misalign_exc  (misalign_exc),
        .perf_branches (perf_branches),
        .perf_taken    (perf_taken)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_pc = 0; ex_imm = 0; alu_c = 0; alu_zero = 0; stall = 0;
    endtask

    task automatic check_out(input string tag, input logic rv, input logic [31:0] rpc,
                             input logic ff, input logic lv, input logic [31:0] ld,
                             input logic me);
        check_eq({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
        check_eq({tag, ".redirect_pc"},    redirect_pc,         rpc);
        check_eq({tag, ".flush_front"},    32'(flush_front),    32'(ff));
        check_eq({tag, ".link_valid"},     32'(link_valid),     32'(lv));
        check_eq({tag, ".link_data"},      link_data,           ld);
        check_eq({tag, ".misalign_exc"},   32'(misalign_exc),   32'(me));
    endtask

    task automatic check_perf(input string tag, input int br, input int tk);
        check_eq({tag, ".perf_branches"}, perf_branches, PERF_ON ? 32'(br) : 32'h0);
        check_eq({tag, ".perf_taken"},    perf_taken,    PERF_ON ? 32'(tk) : 32'h0);
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        step();
        step();
        check_out("reset", 0, 32'h0, 0, 0, 32'h0, 0);
        check_perf("reset", 0, 0);
        rst = 1'b0;

        // beq taken: 0x100 + 0x20
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h100; ex_imm = 32'h20; alu_zero = 1;
        step();
        clear_in();
        check_out("beq.c1", 1, 32'h120, 1, 0, 32'h0, 0);
        check_perf("beq", 1, 1);
        step();
        check_out("beq.c2", 0, 32'h120, 1, 0, 32'h0, 0);
        step();
        check_out("beq.c3", 0, 32'h120, 0, 0, 32'h0, 0);

        // bne not taken
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h200; ex_imm = 32'h40; alu_zero = 0;
        step();
        clear_in();
        check_out("bne", 0, 32'h120, 0, 0, 32'h0, 0);
        check_perf("bne", 2, 1);

        // jalr with misaligned target 0x2003 & ~1 = 0x2002
        ex_valid = 1; ex_is_jalr = 1; ex_pc = 32'h40; alu_c = 32'h2003;
        step();
        clear_in();
        check_out("jalr_mis.c1", 0, 32'h2002, 0, 1, 32'h44, 0 | 1);
        step();
        check_out("jalr_mis.c2", 0, 32'h2002, 0, 0, 32'h44, 0);
        check_perf("jalr_mis", 2, 1);

        // back-to-back jal: second one is a squashed wrong-path op
        ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h80; ex_imm = 32'h100;
        step();
        check_out("b2b.c1", 1, 32'h180, 1, 1, 32'h84, 0);
        ex_pc = 32'h300; ex_imm = 32'h10;
        step();
        check_out("b2b.c2", 0, 32'h180, 1, 0, 32'h84, 0);
        step();
        clear_in();
        check_out("b2b.c3", 0, 32'h180, 0, 0, 32'h84, 0);

        // stalled taken branch: 0x400 + (-4) = 0x3FC
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h400; ex_imm = 32'hFFFF_FFFC;
        alu_zero = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("stall.%0d", i), 0, 32'h180, 0, 0, 32'h84, 0);
        end
        stall = 0;
        step();
        clear_in();
        check_out("stall.rel", 1, 32'h3FC, 1, 0, 32'h84, 0);
        check_perf("stall", 3, 2);
        step();
        check_out("stall.f2", 0, 32'h3FC, 1, 0, 32'h84, 0);

        // async reset during the second flush cycle
        rst = 1'b1;
        #1;
        check_out("rst_mid", 0, 32'h0, 0, 0, 32'h0, 0);
        check_perf("rst_mid", 0, 0);
        step();
        rst = 1'b0;

        // taken branch after reset, target wraps: 0xFFFFFFF0 + 0x20 = 0x10
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20; alu_zero = 1;
        step();
        clear_in();
        check_out("wrap.c1", 1, 32'h10, 1, 0, 32'h0, 0);
        check_perf("wrap", 1, 1);
        step();
        step();
        check_out("wrap.c3", 0, 32'h10, 0, 0, 32'h0, 0);

        // taken branch with misaligned target 0x102
        ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h100; ex_imm = 32'h2; alu_zero = 1;
        step();
        clear_in();
        check_out("br_mis", 0, 32'h102, 0, 0, 32'h0, 1);
        check_perf("br_mis", 2, 2);

        // all three flags: jalr wins, branch not counted
        ex_valid = 1; ex_is_branch = 1; ex_is_jal = 1; ex_is_jalr = 1;
        ex_pc = 32'h10; ex_imm = 32'h8; alu_c = 32'h501; alu_zero = 1;
        step();
        clear_in();
        check_out("prio", 1, 32'h500, 1, 1, 32'h14, 0);
        check_perf("prio", 2, 2);
        step();
        step();
        check_out("prio.end", 0, 32'h500, 0, 0, 32'h14, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
